// File: rtl/count_checker_if.sv
// Sample stream into the count checker and its registered status back out.
// Latency and backpressure belong to the block; this is wiring only.
interface count_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 16
);
    logic                 valid;
    logic [WIDTH-1:0]     count_in;
    logic                 locked;
    logic                 error;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [WIDTH-1:0]     expected;

    modport master (
        output valid, count_in,
        input  locked, error, err_cnt, expected
    );

    modport slave (
        input  valid, count_in,
        output locked, error, err_cnt, expected
    );
endinterface

// File: rtl/count_checker.sv
// Verifies an upstream counter steps by one per valid sample; locks after LOCK_CNT matches.
// Latency 1 cycle (all outputs registered); no backpressure, valid-only sample stream.
module count_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    count_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           run_q, run_d;
    logic [WIDTH-1:0]     last_q, last_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic                 locked_q, locked_d;
    logic                 error_q, error_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 match;
    logic [8:0]           run_inc;

    // Wrap from all-ones to zero falls out of the modular add.
    assign match   = (bus.count_in == last_q + WIDTH'(1));
    assign run_inc = {1'b0, run_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        last_d     = last_q;
        expected_d = expected_q;
        err_cnt_d  = err_cnt_q;
        error_d    = 1'b0;

        if (bus.valid) begin
            last_d     = bus.count_in;
            expected_d = bus.count_in + WIDTH'(1);
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    run_d   = 8'd0;
                end
                ACQUIRE: begin
                    if (match) begin
                        if (run_inc == 9'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            run_d   = 8'd0;
                        end else begin
                            run_d = run_inc[7:0];
                        end
                    end else begin
                        run_d = 8'd0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        // The breaking sample seeds the new run, so relock needs LOCK_CNT more matches.
                        state_d = ACQUIRE;
                        run_d   = 8'd0;
                        error_d = 1'b1;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = 8'd0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            run_q      <= 8'd0;
            last_q     <= '0;
            expected_q <= '0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            last_q     <= last_d;
            expected_q <= expected_d;
            locked_q   <= locked_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.locked   = locked_q;
    assign bus.error    = error_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.expected = expected_q;
endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and checks.
// Instance a uses default widths; instance b has a 2-bit error counter to exercise saturation.
module tb_count_checker;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   pos_cnt = 0;
    int   errors  = 0;
    int   checks  = 0;
    int   step_no = 0;

    always #5 clk = ~clk;
    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    count_checker_if #(.WIDTH(4), .ERR_CNT_W(16)) bus_a ();
    count_checker_if #(.WIDTH(4), .ERR_CNT_W(2))  bus_b ();

    count_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    count_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    typedef struct {
        bit          sel;
        int          due;
        int          tag;
        bit          lock;
        bit          err;
        logic [15:0] cnt;
        logic [3:0]  exp;
    } exp_t;

    exp_t sb[$];

    task automatic cmp(input string name, input int tag, input bit sel,
                       input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d dut_%s %s: got %0d want %0d",
                     tag, sel ? "b" : "a", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= pos_cnt) begin
            exp_t e;
            e = sb.pop_front();
            if (e.sel == 1'b0) begin
                cmp("locked",   e.tag, 0, 16'(bus_a.locked),   16'(e.lock));
                cmp("error",    e.tag, 0, 16'(bus_a.error),    16'(e.err));
                cmp("err_cnt",  e.tag, 0, bus_a.err_cnt,       e.cnt);
                cmp("expected", e.tag, 0, 16'(bus_a.expected), 16'(e.exp));
            end else begin
                cmp("locked",   e.tag, 1, 16'(bus_b.locked),   16'(e.lock));
                cmp("error",    e.tag, 1, 16'(bus_b.error),    16'(e.err));
                cmp("err_cnt",  e.tag, 1, 16'(bus_b.err_cnt),  e.cnt);
                cmp("expected", e.tag, 1, 16'(bus_b.expected), 16'(e.exp));
            end
        end
    end

    // One clock of stimulus on the selected instance; the other idles with random count_in.
    task automatic step(input bit sel, input bit rst, input bit v, input int cin,
                        input bit el, input bit ee, input int ec, input int ex);
        exp_t e;
        @(posedge clk);
        #1;
        rst_a          = (sel == 1'b0) ? rst : 1'b0;
        rst_b          = (sel == 1'b1) ? rst : 1'b0;
        bus_a.valid    = (sel == 1'b0) ? v : 1'b0;
        bus_b.valid    = (sel == 1'b1) ? v : 1'b0;
        bus_a.count_in = (sel == 1'b0 && v) ? 4'(cin) : 4'($urandom_range(0, 15));
        bus_b.count_in = (sel == 1'b1 && v) ? 4'(cin) : 4'($urandom_range(0, 15));
        step_no++;
        e.sel  = sel;
        e.due  = pos_cnt + 1;
        e.tag  = step_no;
        e.lock = el;
        e.err  = ee;
        e.cnt  = 16'(ec);
        e.exp  = 4'(ex);
        sb.push_back(e);
    endtask

    // Sample shorthand: valid=1, no reset.
    task automatic smp(input bit sel, input int cin, input bit el, input bit ee,
                       input int ec, input int ex);
        step(sel, 1'b0, 1'b1, cin, el, ee, ec, ex);
    endtask

    task automatic idle(input bit sel, input bit el, input int ec, input int ex);
        step(sel, 1'b0, 1'b0, 0, el, 1'b0, ec, ex);
    endtask

    task automatic rst(input bit sel);
        step(sel, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.valid = 1'b0; bus_a.count_in = '0;
        bus_b.valid = 1'b0; bus_b.count_in = '0;

        // Reset, then acquire lock on 5,6,7,8
        rst(0); rst(0);
        smp(0, 5, 0, 0, 0, 6);
        smp(0, 6, 0, 0, 0, 7);
        smp(0, 7, 0, 0, 0, 8);
        smp(0, 8, 1, 0, 0, 9);
        // Stay locked through wrap 14,15,0,1
        for (int i = 9; i <= 13; i++) smp(0, i, 1, 0, 0, i + 1);
        smp(0, 14, 1, 0, 0, 15);
        smp(0, 15, 1, 0, 0, 0);
        smp(0, 0,  1, 0, 0, 1);
        smp(0, 1,  1, 0, 0, 2);
        smp(0, 2,  1, 0, 0, 3);
        smp(0, 3,  1, 0, 0, 4);
        // Break while locked with last=3, relock after 12
        smp(0, 9,  0, 1, 1, 10);
        smp(0, 10, 0, 0, 1, 11);
        smp(0, 11, 0, 0, 1, 12);
        smp(0, 12, 1, 0, 1, 13);

        // Mismatch during ACQUIRE: no error, run restarts at the bad sample
        rst(0);
        smp(0, 2, 0, 0, 0, 3);
        smp(0, 3, 0, 0, 0, 4);
        smp(0, 7, 0, 0, 0, 8);
        smp(0, 8, 0, 0, 0, 9);
        smp(0, 9, 0, 0, 0, 10);
        smp(0, 10, 1, 0, 0, 11);

        // Gapped samples with random count_in during idle cycles
        rst(0);
        smp(0, 2, 0, 0, 0, 3);
        idle(0, 0, 0, 3);
        smp(0, 3, 0, 0, 0, 4);
        idle(0, 0, 0, 4); idle(0, 0, 0, 4);
        smp(0, 4, 0, 0, 0, 5);
        idle(0, 0, 0, 5); idle(0, 0, 0, 5); idle(0, 0, 0, 5);
        smp(0, 5, 1, 0, 0, 6);
        idle(0, 1, 0, 6);

        // Saturating 2-bit error counter
        rst(1); rst(1);
        smp(1, 0, 0, 0, 0, 1);
        smp(1, 1, 0, 0, 0, 2);
        smp(1, 2, 0, 0, 0, 3);
        smp(1, 3, 1, 0, 0, 4);
        smp(1, 8, 0, 1, 1, 9);
        smp(1, 9, 0, 0, 1, 10);
        smp(1, 10, 0, 0, 1, 11);
        smp(1, 11, 1, 0, 1, 12);
        smp(1, 0, 0, 1, 2, 1);
        smp(1, 1, 0, 0, 2, 2);
        smp(1, 2, 0, 0, 2, 3);
        smp(1, 3, 1, 0, 2, 4);
        smp(1, 7, 0, 1, 3, 8);
        smp(1, 8, 0, 0, 3, 9);
        smp(1, 9, 0, 0, 3, 10);
        smp(1, 10, 1, 0, 3, 11);
        smp(1, 0, 0, 1, 3, 1);
        idle(1, 0, 3, 1);
        smp(1, 1, 0, 0, 3, 2);
        // Reset beats a concurrent valid sample mid-ACQUIRE
        step(1, 1'b1, 1'b1, 2, 0, 0, 0, 0);
        smp(1, 5, 0, 0, 0, 6);

        @(posedge clk);
        #1;
        bus_a.valid = 1'b0;
        bus_b.valid = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
